// File: rtl/frac_to_digits.sv
// ============================================================================
//  Module   : frac_to_digits
//  Brief    : Binary fraction to decimal digit stream (repeated multiply-by-10)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module frac_to_digits #(
    parameter int P_WIDTH  = 16,
    parameter int P_DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [P_WIDTH-1:0] i_fraction_in,
    output logic               o_busy,
    output logic               o_digit_valid,
    input  logic               i_digit_ready,
    output logic [3:0]         o_digit_out,
    output logic               o_digit_last,
    output logic               o_done
);

    localparam int CW = $clog2(P_DIGITS) + 1;
    localparam logic [CW-1:0] c_LAST_IDX = CW'(P_DIGITS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OUT  = 1'b1
    } state_t;

    state_t             r_state;
    logic [P_WIDTH-1:0] r_frac;
    logic [CW-1:0]      r_count;
    logic [3:0]         r_digit;
    logic               r_valid;
    logic               r_last;
    logic               r_done;

    logic [P_WIDTH+3:0] w_prod_in;
    logic [P_WIDTH+3:0] w_prod_frac;
    logic [CW-1:0]      w_count_inc;
    logic               w_handshake;

    // x*10 as (x<<3)+(x<<1); the top nibble is the next digit, always 0..9
    assign w_prod_in   = ({4'b0000, i_fraction_in} << 3) + ({4'b0000, i_fraction_in} << 1);
    assign w_prod_frac = ({4'b0000, r_frac} << 3) + ({4'b0000, r_frac} << 1);
    assign w_count_inc = r_count + 1'b1;
    assign w_handshake = r_valid & i_digit_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_frac  <= '0;
            r_count <= '0;
            r_digit <= 4'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_digit <= w_prod_in[P_WIDTH+3:P_WIDTH];
                        r_frac  <= w_prod_in[P_WIDTH-1:0];
                        r_count <= '0;
                        r_valid <= 1'b1;
                        r_last  <= (P_DIGITS == 1);
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (w_handshake) begin
                        if (r_count == c_LAST_IDX) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_digit <= w_prod_frac[P_WIDTH+3:P_WIDTH];
                            r_frac  <= w_prod_frac[P_WIDTH-1:0];
                            r_count <= w_count_inc;
                            r_last  <= (w_count_inc == c_LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_digit_valid = r_valid;
    assign o_digit_out   = r_digit;
    assign o_digit_last  = r_last;
    assign o_done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_frac_to_digits.sv
// ============================================================================
//  Module   : tb_frac_to_digits
//  Brief    : Directed self-checking bench for frac_to_digits
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_frac_to_digits;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_fraction_in = 16'h0000;
    logic        i_digit_ready = 1'b0;
    logic        o_busy, o_digit_valid, o_digit_last, o_done;
    logic [3:0]  o_digit_out;

    logic        i_start1 = 1'b0;
    logic [15:0] i_fraction_in1 = 16'h0000;
    logic        i_digit_ready1 = 1'b0;
    logic        o_busy1, o_digit_valid1, o_digit_last1, o_done1;
    logic [3:0]  o_digit_out1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frac_to_digits #(.P_WIDTH(16), .P_DIGITS(4)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_fraction_in (i_fraction_in),
        .o_busy        (o_busy),
        .o_digit_valid (o_digit_valid),
        .i_digit_ready (i_digit_ready),
        .o_digit_out   (o_digit_out),
        .o_digit_last  (o_digit_last),
        .o_done        (o_done)
    );

    frac_to_digits #(.P_WIDTH(16), .P_DIGITS(1)) u_dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start1),
        .i_fraction_in (i_fraction_in1),
        .o_busy        (o_busy1),
        .o_digit_valid (o_digit_valid1),
        .i_digit_ready (i_digit_ready1),
        .o_digit_out   (o_digit_out1),
        .o_digit_last  (o_digit_last1),
        .o_done        (o_done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge one cycle after start was accepted. Consumes four
    // digits, then leaves the bench on the negedge where done must be high.
    task automatic run_stream(input string tag, input logic [15:0] exp_word,
                              input bit rnd, input bit poke);
        int idx = 0;
        int guard = 0;
        chk({tag, "_first_valid"}, {31'd0, o_digit_valid}, 32'd1);
        while (idx < 4 && guard < 200) begin
            i_start = 1'b0;
            if (o_digit_valid) begin
                chk({tag, "_digit"}, {28'd0, o_digit_out}, {28'd0, exp_word[15-4*idx -: 4]});
                chk({tag, "_last"}, {31'd0, o_digit_last}, {31'd0, (idx == 3)});
                chk({tag, "_done_low"}, {31'd0, o_done}, 32'd0);
                if (poke && idx == 2) begin
                    i_start       = 1'b1;
                    i_fraction_in = 16'hFFFF;
                end
                i_digit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (i_digit_ready) idx++;
            end
            @(negedge clk);
            guard++;
        end
        i_start = 1'b0;
        if (guard >= 200) chk({tag, "_timeout"}, 32'd1, 32'd0);
        chk({tag, "_done"}, {31'd0, o_done}, 32'd1);
        chk({tag, "_valid_off"}, {31'd0, o_digit_valid}, 32'd0);
        chk({tag, "_busy_off"}, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic launch(input logic [15:0] frac);
        i_start       = 1'b1;
        i_fraction_in = frac;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_valid", {31'd0, o_digit_valid}, 32'd0);
        chk("rst_digit", {28'd0, o_digit_out}, 32'd0);
        chk("rst_last", {31'd0, o_digit_last}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: pi fraction, ready held high
        launch(16'h243F);
        chk("t1_busy", {31'd0, o_busy}, 32'd1);
        run_stream("t1", 16'h1415, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_done_pulse_end", {31'd0, o_done}, 32'd0);

        // 2: boundary fractions
        launch(16'h8000);
        run_stream("t2a", 16'h5000, 1'b0, 1'b0);
        launch(16'hFFFF);
        run_stream("t2b", 16'h9999, 1'b0, 1'b0);
        launch(16'h0000);
        run_stream("t2c", 16'h0000, 1'b0, 1'b0);

        // 3: random backpressure
        launch(16'h243F);
        run_stream("t3", 16'h1415, 1'b1, 1'b0);

        // 4: start while busy ignored, then start on the done cycle
        launch(16'h243F);
        run_stream("t4a", 16'h1415, 1'b0, 1'b1);
        launch(16'hFFFF);
        run_stream("t4b", 16'h9999, 1'b0, 1'b0);

        // 5: async reset after the second digit
        launch(16'h243F);
        i_digit_ready = 1'b1;
        chk("t5_d0", {28'd0, o_digit_out}, 32'd1);
        @(negedge clk);
        chk("t5_d1", {28'd0, o_digit_out}, 32'd4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, o_digit_valid}, 32'd0);
        chk("t5_rst_digit", {28'd0, o_digit_out}, 32'd0);
        chk("t5_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("t5_rst_last", {31'd0, o_digit_last}, 32'd0);
        @(negedge clk);
        chk("t5_rst_done", {31'd0, o_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_no_done", {31'd0, o_done}, 32'd0);
        launch(16'h8000);
        run_stream("t5", 16'h5000, 1'b0, 1'b0);

        // 6: single-digit instance
        i_digit_ready1 = 1'b1;
        i_start1       = 1'b1;
        i_fraction_in1 = 16'h243F;
        @(negedge clk);
        i_start1 = 1'b0;
        chk("t6_valid", {31'd0, o_digit_valid1}, 32'd1);
        chk("t6_digit", {28'd0, o_digit_out1}, 32'd1);
        chk("t6_last", {31'd0, o_digit_last1}, 32'd1);
        chk("t6_done_low", {31'd0, o_done1}, 32'd0);
        @(negedge clk);
        chk("t6_done", {31'd0, o_done1}, 32'd1);
        chk("t6_valid_off", {31'd0, o_digit_valid1}, 32'd0);
        chk("t6_last_off", {31'd0, o_digit_last1}, 32'd0);
        @(negedge clk);
        chk("t6_done_end", {31'd0, o_done1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
